// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the 3-digit BCD display scanner.
package bcd_disp_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_t;

  localparam int   N_DIGITS  = 3;
  localparam seg_t SEG_DASH  = 7'b1000000;  // only segment g lit
  localparam seg_t SEG_BLANK = 7'b0000000;

  // True when any of the three packed nibbles is outside 0..9.
  function automatic logic bcd_has_invalid(input logic [11:0] value);
    return (value[3:0] > 4'd9) || (value[7:4] > 4'd9) || (value[11:8] > 4'd9);
  endfunction

  // One-hot digit enable for a digit index; out-of-range indices stay dark.
  function automatic logic [2:0] digit_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bcd_display_scan_bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment decoder, segments {g,f,e,d,c,b,a}
// active-high. Non-decimal nibbles return blank and raise invalid so the
// caller chooses how to present them.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg,
  output logic       invalid
);

  // Standard decimal patterns; A-F flagged invalid.
  always_comb begin
    invalid = 1'b0;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: begin
        seg     = SEG_BLANK;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Captures a packed 3-digit BCD value on load and time-division scans it
// onto a multiplexed 7-segment display (units first). The display stays
// dark until the first capture.
// Optional build macro LZ_BLANK_EN: blank leading-zero hundreds/tens
// digits (digit enable still asserted, segments off).
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 4,   // cycles each digit stays lit, >= 2
  parameter int CNT_W       = 16   // prescaler width, must hold REFRESH_DIV-1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] bcd_in,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        digit_err,
  output logic        loaded
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);

  logic             state_q,  state_d;
  logic [11:0]      held_q,   held_d;
  logic [CNT_W-1:0] presc_q,  presc_d;
  logic [1:0]       idx_q,    idx_d;
  logic [6:0]       seg_q,    seg_d;
  logic [2:0]       an_q,     an_d;
  logic             err_q,    err_d;
  logic             loaded_q, loaded_d;

  bcd_digit_t cur_digit;
  seg_t       dec_seg;
  logic       dec_invalid;
  seg_t       disp_seg;
  logic       blank_digit;

  // Select the held nibble for the digit currently being scanned.
  always_comb begin
    case (idx_q)
      2'd0:    cur_digit = held_q[3:0];
      2'd1:    cur_digit = held_q[7:4];
      2'd2:    cur_digit = held_q[11:8];
      default: cur_digit = 4'd0;
    endcase
  end

  bcd_to_7seg u_dec (
    .digit   (cur_digit),
    .seg     (dec_seg),
    .invalid (dec_invalid)
  );

  // Decide whether the current digit is a suppressed leading zero.
`ifdef LZ_BLANK_EN
  always_comb begin
    blank_digit = 1'b0;
    if (idx_q == 2'd2 && held_q[11:8] == 4'd0)
      blank_digit = 1'b1;
    else if (idx_q == 2'd1 && held_q[11:8] == 4'd0 && held_q[7:4] == 4'd0)
      blank_digit = 1'b1;
  end
`else
  always_comb begin
    blank_digit = 1'b0;
  end
`endif

  // Final segment pattern: dash for non-decimal nibbles, blank for leading zeros.
  always_comb begin
    if (dec_invalid)      disp_seg = SEG_DASH;
    else if (blank_digit) disp_seg = SEG_BLANK;
    else                  disp_seg = dec_seg;
  end

  // Capture, prescaler/digit sequencing and the registered display outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    held_d   = held_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    err_d    = err_q;
    loaded_d = loaded_q;
    seg_d    = SEG_BLANK;
    an_d     = 3'b000;

    if (load) begin
      // Restart at units; hold the display dark for the capture cycle so
      // no stale digit of the previous value is drawn.
      state_d  = ST_SCAN;
      held_d   = bcd_in;
      presc_d  = '0;
      idx_d    = 2'd0;
      err_d    = bcd_has_invalid(bcd_in);
      loaded_d = 1'b1;
    end else if (state_q == ST_SCAN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        idx_d   = (idx_q == 2'(N_DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      seg_d = disp_seg;
      an_d  = digit_onehot(idx_q);
    end
  end

  // State registers; reset wins over load in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      held_q   <= '0;
      presc_q  <= '0;
      idx_q    <= 2'd0;
      seg_q    <= SEG_BLANK;
      an_q     <= 3'b000;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign digit_err = err_q;
  assign loaded    = loaded_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed self-checking bench for bcd_display_scan (REFRESH_DIV=4).
// Expected leading-zero behaviour follows LZ_BLANK_EN when defined.
module tb_bcd_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [11:0] bcd_in;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        digit_err;
  logic        loaded;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en   = 1'b0;

`ifdef LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P3 = 7'h4F,
                         P4 = 7'h66, P5 = 7'h6D, P7 = 7'h07, DASH = 7'h40;
  localparam logic [6:0] LZ0 = LZ ? 7'h00 : P0;  // leading zero as displayed

  bcd_display_scan #(.REFRESH_DIV(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .bcd_in    (bcd_in),
    .seg       (seg),
    .an        (an),
    .digit_err (digit_err),
    .loaded    (loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Digit enables must never have more than one bit high.
  always @(negedge clk) begin
    if (mon_en) check("an_onehot0", 32'($onehot0(an)), 32'd1);
  end

  // Advance one clock; returns at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [11:0] v);
    bcd_in = v;
    load   = 1'b1;
    cyc();
    load   = 1'b0;
  endtask

  // Check a full 4-cycle digit slot, leaving the bench at the next slot.
  task automatic check_slot(input string tag, input logic [2:0] a, input logic [6:0] s);
    repeat (4) begin
      check({tag, "_an"}, 32'(an), 32'(a));
      check({tag, "_seg"}, 32'(seg), 32'(s));
      cyc();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = 12'h000;
    @(negedge clk);
    cyc(); cyc();
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_an", 32'(an), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_err", 32'(digit_err), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (20) begin
      cyc();
      check("idle_an", 32'(an), 32'd0);
      check("idle_seg", 32'(seg), 32'd0);
    end

    // Basic capture and scan order.
    do_load(12'h054);
    check("t2_loaded", 32'(loaded), 32'd1);
    check("t2_err", 32'(digit_err), 32'd0);
    cyc();
    check_slot("t2_u", 3'b001, P4);
    check_slot("t2_t", 3'b010, P5);
    check_slot("t2_h", 3'b100, LZ0);
    check_slot("t2_wrap", 3'b001, P4);

    // Two leading zeros.
    do_load(12'h007);
    cyc();
    check_slot("t3_u", 3'b001, P7);
    check_slot("t3_t", 3'b010, LZ0);
    check_slot("t3_h", 3'b100, LZ0);

    // Load held several cycles: last value wins.
    bcd_in = 12'h111; load = 1'b1; cyc();
    bcd_in = 12'h222; cyc();
    bcd_in = 12'h054; cyc();
    load = 1'b0;
    cyc();
    check_slot("hold_u", 3'b001, P4);
    check_slot("hold_t", 3'b010, P5);

    // Reload in the middle of the tens slot.
    do_load(12'h054);
    cyc();
    check_slot("t4_pre", 3'b001, P4);
    cyc(); cyc();
    check("t4_mid_an", 32'(an), 32'b010);
    do_load(12'h255);
    cyc();
    check_slot("t4_u", 3'b001, P5);
    check_slot("t4_t", 3'b010, P5);
    check_slot("t4_h", 3'b100, P2);

    // Invalid nibble shows a dash and raises digit_err.
    do_load(12'h0A3);
    check("t5_err_set", 32'(digit_err), 32'd1);
    cyc();
    check_slot("t5_u", 3'b001, P3);
    check_slot("t5_t", 3'b010, DASH);
    check_slot("t5_h", 3'b100, LZ0);
    do_load(12'h123);
    check("t5_err_clr", 32'(digit_err), 32'd0);
    cyc();
    check_slot("t5b_u", 3'b001, P3);
    check_slot("t5b_t", 3'b010, P2);
    check_slot("t5b_h", 3'b100, P1);

    // Reset together with load mid-scan.
    cyc(); cyc();
    rst = 1'b1; load = 1'b1; bcd_in = 12'h999;
    cyc();
    rst = 1'b0; load = 1'b0;
    check("t6_seg", 32'(seg), 32'd0);
    check("t6_an", 32'(an), 32'd0);
    check("t6_loaded", 32'(loaded), 32'd0);
    check("t6_err", 32'(digit_err), 32'd0);
    repeat (6) begin
      cyc();
      check("t6_idle_an", 32'(an), 32'd0);
      check("t6_idle_seg", 32'(seg), 32'd0);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
